cla_addsub_pipe: RTL and testbench

Two-stage pipelined WIDTH-bit adder/subtractor built on 4-bit carry-lookahead groups. It sits directly downstream of the 4-bit lookahead carry unit. Stage 1 forms per-bit generate/transmit terms and the group carry-ins. Stage 2 consumes them through per-nibble 4-bit lookahead to form the sum and the NZCV flags. A valid/ready handshake on both sides provides throughput of one operation per cycle with backpressure.

---
 rtl/cla_addsub_pipe.sv | 146 ++++++++++++++
 tb/tb_cla_addsub_pipe.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/cla_addsub_pipe.sv
// Two-stage pipelined adder/subtractor on 4-bit carry-lookahead groups.
// Stage 1 forms bit terms and group carries, stage 2 forms sum and NZCV.
module cla_addsub_pipe #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_n,
  output logic             out_z,
  output logic             out_c,
  output logic             out_v,
  output logic [TAG_W-1:0] out_tag
);

  localparam int NIB = WIDTH / 4;

  logic s2_adv;
  logic s1_adv;

  logic [WIDTH-1:0] bx;
  logic [WIDTH-1:0] g_d;
  logic [WIDTH-1:0] t_d;
  logic [WIDTH-1:0] p_d;
  logic [NIB-1:0]   gg;
  logic [NIB-1:0]   gt;
  logic [NIB:0]     cg_d;
  logic             prod;

  logic                  s1_valid;
  logic [NIB-1:0][2:0]   s1_g;
  logic [NIB-1:0][2:0]   s1_t;
  logic [WIDTH-1:0]      s1_p;
  logic [NIB:0]          s1_cg;
  logic [TAG_W-1:0]      s1_tag;

  logic [WIDTH-1:0] cin;
  logic [WIDTH-1:0] sum_d;
  logic             c_d;
  logic             v_d;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  always_comb begin
    bx   = in_b ^ {WIDTH{in_sub}};
    g_d  = in_a & bx;
    t_d  = in_a | bx;
    p_d  = in_a ^ bx;
    gg   = '0;
    gt   = '0;
    cg_d = '0;
    prod = 1'b0;
    for (int k = 0; k < NIB; k++) begin
      gg[k] = g_d[4*k+3]
            | (t_d[4*k+3] & g_d[4*k+2])
            | (t_d[4*k+3] & t_d[4*k+2] & g_d[4*k+1])
            | (t_d[4*k+3] & t_d[4*k+2] & t_d[4*k+1] & g_d[4*k]);
      gt[k] = &t_d[4*k +: 4];
    end
    cg_d[0] = in_sub;
    // Each group carry is a flat OR of products, never chained through cg_d[k]
    for (int k = 0; k < NIB; k++) begin
      for (int j = 0; j <= k; j++) begin
        prod = gg[j];
        for (int m = j + 1; m <= k; m++)
          prod = prod & gt[m];
        cg_d[k+1] = cg_d[k+1] | prod;
      end
      prod = in_sub;
      for (int m = 0; m <= k; m++)
        prod = prod & gt[m];
      cg_d[k+1] = cg_d[k+1] | prod;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_g     <= '0;
      s1_t     <= '0;
      s1_p     <= '0;
      s1_cg    <= '0;
      s1_tag   <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      for (int k = 0; k < NIB; k++) begin
        s1_g[k] <= g_d[4*k +: 3];
        s1_t[k] <= t_d[4*k +: 3];
      end
      s1_p     <= p_d;
      s1_cg    <= cg_d;
      s1_tag   <= in_tag;
    end
  end

  always_comb begin
    cin = '0;
    for (int k = 0; k < NIB; k++) begin
      cin[4*k]   = s1_cg[k];
      cin[4*k+1] = s1_g[k][0]
                 | (s1_t[k][0] & s1_cg[k]);
      cin[4*k+2] = s1_g[k][1]
                 | (s1_t[k][1] & s1_g[k][0])
                 | (s1_t[k][1] & s1_t[k][0] & s1_cg[k]);
      cin[4*k+3] = s1_g[k][2]
                 | (s1_t[k][2] & s1_g[k][1])
                 | (s1_t[k][2] & s1_t[k][1] & s1_g[k][0])
                 | (s1_t[k][2] & s1_t[k][1] & s1_t[k][0] & s1_cg[k]);
    end
    sum_d = s1_p ^ cin;
    c_d   = s1_cg[NIB];
    v_d   = cin[WIDTH-1] ^ s1_cg[NIB];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_n     <= 1'b0;
      out_z     <= 1'b0;
      out_c     <= 1'b0;
      out_v     <= 1'b0;
      out_tag   <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      out_sum   <= sum_d;
      out_n     <= sum_d[WIDTH-1];
      out_z     <= ~|sum_d;
      out_c     <= c_d;
      out_v     <= v_d;
      out_tag   <= s1_tag;
    end
  end

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Directed and streamed checks for cla_addsub_pipe.
// Covers flags, latency, backpressure, ordering and async reset.
module tb_cla_addsub_pipe;

  localparam int W  = 32;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic          in_sub;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_sum;
  logic          out_n;
  logic          out_z;
  logic          out_c;
  logic          out_v;
  logic [TW-1:0] out_tag;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cla_addsub_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_a(in_a),
    .in_b(in_b),
    .in_sub(in_sub),
    .in_tag(in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum(out_sum),
    .out_n(out_n),
    .out_z(out_z),
    .out_c(out_c),
    .out_v(out_v),
    .out_tag(out_tag)
  );

  task automatic chk(input string nm, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", nm, obs, exp);
    end
  endtask

  function automatic logic [39:0] obs_word();
    return {out_tag, out_n, out_z, out_c, out_v, out_sum};
  endfunction

  // Reference: plain wide addition, overflow from operand/result signs
  function automatic logic [39:0] ref_op(input logic [W-1:0] a,
                                         input logic [W-1:0] b,
                                         input logic sub,
                                         input logic [TW-1:0] tag);
    logic [W-1:0] bb;
    logic [W:0]   r;
    logic [W-1:0] s;
    logic         v;
    bb = sub ? ~b : b;
    r  = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, sub};
    s  = r[W-1:0];
    v  = (a[W-1] == bb[W-1]) && (s[W-1] != a[W-1]);
    return {tag, s[W-1], (s == '0), r[W], v, s};
  endfunction

  task automatic run_one(input string nm, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic sub,
                         input logic [TW-1:0] tag,
                         input logic [W-1:0] e_sum,
                         input logic [3:0] e_nzcv);
    @(negedge clk);
    in_valid  = 1'b1;
    in_a      = a;
    in_b      = b;
    in_sub    = sub;
    in_tag    = tag;
    out_ready = 1'b1;
    #1 chk({nm, "_rdy"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk({nm, "_lat"}, out_valid, 0);
    @(negedge clk);
    chk({nm, "_vld"}, out_valid, 1);
    chk(nm, obs_word(), {tag, e_nzcv, e_sum});
  endtask

  logic [39:0] q[$];
  logic [39:0] held;
  bit          stalled;
  bit          m_s1;
  bit          m_ov;
  bit          iv;
  bit          xo;
  bit          s2a;
  bit          s1a;
  int          sent;
  int          got;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_sub    = 1'b0;
    in_tag    = '0;
    out_ready = 1'b0;
    #12;
    chk("rst_ovld", out_valid, 0);
    chk("rst_pay", obs_word(), 0);
    chk("rst_rdy", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    run_one("add_wrap", 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 4'd3,
            32'h0000_0000, 4'b0110);
    run_one("add_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 4'd4,
            32'h8000_0000, 4'b1001);
    run_one("sub_ovf", 32'h8000_0000, 32'h0000_0001, 1'b1, 4'd5,
            32'h7FFF_FFFF, 4'b0011);
    run_one("sub_brw", 32'h0000_0005, 32'h0000_0007, 1'b1, 4'd6,
            32'hFFFF_FFFE, 4'b1000);
    run_one("sub_eq", 32'h0000_0007, 32'h0000_0007, 1'b1, 4'd7,
            32'h0000_0000, 4'b0110);
    run_one("carry_all", 32'h0FFF_FFFF, 32'h0000_0001, 1'b0, 4'd8,
            32'h1000_0000, 4'b0000);
    run_one("add_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 4'd9,
            32'hFFFF_FFFE, 4'b1010);
    run_one("sub_zero", 32'h0000_0000, 32'h0000_0000, 1'b1, 4'd10,
            32'h0000_0000, 4'b0110);

    // Streamed ops with random backpressure against a flow model
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(negedge clk);
    m_s1    = 1'b0;
    m_ov    = 1'b0;
    stalled = 1'b0;
    held    = '0;
    sent    = 0;
    got     = 0;
    for (int cyc = 0; cyc < 400 && got < 16; cyc++) begin
      if (cyc != 0) @(negedge clk);
      chk("s_ovld", out_valid, m_ov);
      if (m_ov) chk("s_pay", obs_word(), q[0]);
      if (stalled) chk("s_hold", obs_word(), held);
      out_ready = ($urandom_range(0, 2) != 0);
      iv        = (sent < 16) && ($urandom_range(0, 3) != 0);
      in_valid  = iv;
      in_a      = $urandom;
      in_b      = (sent % 3 == 0) ? ~in_a : $urandom;
      in_sub    = $urandom_range(0, 1);
      in_tag    = sent[TW-1:0];
      #1 chk("s_rdy", in_ready, !(m_s1 && m_ov && !out_ready));
      xo      = m_ov && out_ready;
      s2a     = !m_ov || out_ready;
      s1a     = !m_s1 || s2a;
      stalled = m_ov && !out_ready;
      held    = obs_word();
      if (xo) begin
        void'(q.pop_front());
        got++;
      end
      if (s2a) m_ov = m_s1;
      if (s1a) m_s1 = iv;
      if (iv && s1a) begin
        q.push_back(ref_op(in_a, in_b, in_sub, in_tag));
        sent++;
      end
    end
    chk("s_drained", got, 16);
    chk("s_qempty", q.size(), 0);

    // Fill both stages, then reset asynchronously mid-cycle
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_a      = 32'h1111_1111;
    in_b      = 32'h2222_2222;
    in_sub    = 1'b0;
    in_tag    = 4'd1;
    @(negedge clk);
    in_tag    = 4'd2;
    @(negedge clk);
    in_valid  = 1'b0;
    chk("f_ovld", out_valid, 1);
    chk("f_rdy", in_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_ovld", out_valid, 0);
    chk("ar_pay", obs_word(), 0);
    chk("ar_rdy", in_ready, 1);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("ar_stale1", out_valid, 0);
    @(negedge clk);
    chk("ar_stale2", out_valid, 0);
    run_one("post_rst", 32'h0000_1234, 32'h0000_1111, 1'b0, 4'd9,
            32'h0000_2345, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
